axis_packet_arbiter: RTL

Two-input, one-output AXI4-Stream packet arbiter that shares a single downstream consumer between two stream sources. It sits in front of shared modem datapath blocks such as the TX modulator chain or a DMA S2MM port, and merges, for example, pilot/preamble and payload streams. Arbitration is round-robin at packet granularity: once granted, a source keeps the output until its `tlast` beat transfers, so packets are never interleaved. Per-source packet counters and the current grant are exported for status registers.

---
 rtl/axis_arb_pkg.sv | 14 +
 rtl/axis_rr_pick2.sv | 20 ++
 rtl/axis_packet_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/axis_arb_pkg.sv
// Shared encodings for the AXI4-Stream packet arbiters.
// The FSM state doubles as the exported grant value.
package axis_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_t;

    // s00 wins the first tie after reset because s01 counts as last served.
    localparam logic LAST_SERVED_RST = 1'b1;

endpackage

// File: rtl/axis_rr_pick2.sv
// Two-requester round-robin pick: one-hot winner, or 00 when nobody requests.
// Purely combinational so it can be reused in wider arbiter trees.
module axis_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] pick
);

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_served ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Two-input AXI4-Stream arbiter with packet-granular round-robin and per-source packet counters.
// Data passes through combinationally; only state, pointer and counters are registered.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                            axis_aclk,
    input  logic                            axis_aresetn,
    input  logic                            s00_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                            s00_axis_tlast,
    output logic                            s00_axis_tready,
    input  logic                            s01_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0]     s01_axis_tdata,
    input  logic [AXIS_TDATA_WIDTH/8-1:0]   s01_axis_tstrb,
    input  logic                            s01_axis_tlast,
    output logic                            s01_axis_tready,
    output logic                            m00_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                            m00_axis_tlast,
    input  logic                            m00_axis_tready,
    output logic [1:0]                      grant,
    output logic [CNT_WIDTH-1:0]            s00_pkt_count,
    output logic [CNT_WIDTH-1:0]            s01_pkt_count
);

    arb_state_t state, state_nxt;
    logic       last_served, last_served_nxt;
    logic [1:0] pick;
    logic       done0, done1;

    axis_rr_pick2 u_pick (
        .req        ({s01_axis_tvalid, s00_axis_tvalid}),
        .last_served(last_served),
        .pick       (pick)
    );

    // A packet ends when the granted source's tlast beat is accepted downstream.
    assign done0 = (state == GRANT0) && s00_axis_tvalid && m00_axis_tready && s00_axis_tlast;
    assign done1 = (state == GRANT1) && s01_axis_tvalid && m00_axis_tready && s01_axis_tlast;

    always_comb begin
        state_nxt       = state;
        last_served_nxt = last_served;
        case (state)
            IDLE: begin
                if (pick == 2'b01)      state_nxt = GRANT0;
                else if (pick == 2'b10) state_nxt = GRANT1;
            end
            GRANT0: begin
                if (done0) begin
                    state_nxt       = IDLE;
                    last_served_nxt = 1'b0;
                end
            end
            GRANT1: begin
                if (done1) begin
                    state_nxt       = IDLE;
                    last_served_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state         <= IDLE;
            last_served   <= LAST_SERVED_RST;
            s00_pkt_count <= '0;
            s01_pkt_count <= '0;
        end else begin
            state       <= state_nxt;
            last_served <= last_served_nxt;
            if (done0) s00_pkt_count <= s00_pkt_count + CNT_WIDTH'(1);
            if (done1) s01_pkt_count <= s01_pkt_count + CNT_WIDTH'(1);
        end
    end

    assign grant = state;

    // Output mux and ready steering: the non-granted source is always held off.
    always_comb begin
        m00_axis_tvalid = 1'b0;
        m00_axis_tdata  = '0;
        m00_axis_tstrb  = '0;
        m00_axis_tlast  = 1'b0;
        s00_axis_tready = 1'b0;
        s01_axis_tready = 1'b0;
        case (state)
            GRANT0: begin
                m00_axis_tvalid = s00_axis_tvalid;
                m00_axis_tdata  = s00_axis_tdata;
                m00_axis_tstrb  = s00_axis_tstrb;
                m00_axis_tlast  = s00_axis_tlast;
                s00_axis_tready = m00_axis_tready;
            end
            GRANT1: begin
                m00_axis_tvalid = s01_axis_tvalid;
                m00_axis_tdata  = s01_axis_tdata;
                m00_axis_tstrb  = s01_axis_tstrb;
                m00_axis_tlast  = s01_axis_tlast;
                s01_axis_tready = m00_axis_tready;
            end
            default: ;
        endcase
    end

endmodule
